pixel_stream_transmitter: RTL and testbench

Image source for the input layer. Accepts a binary image as a burst of packed words from the host side, holds it in an internal frame buffer, and then serially streams one pixel per clock into the input layer controller. It drives `inputs_inbound`/`pixel_value` and observes `ready_for_inputs`. Output timing satisfies the controller's frame rule: `inputs_inbound` is contiguous for exactly one frame, and `pixel_value` carries pixel k on the k-th inbound cycle.

---
 rtl/pixel_stream_transmitter.sv | 75 +++++++
 tb/tb_pixel_stream_transmitter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pixel_stream_transmitter.sv
// pixel_stream_transmitter: buffers a packed binary frame and streams it one pixel per clock.
module pixel_stream_transmitter #(
  parameter int NUM_PIXELS = 784,
  parameter int WORD_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_valid,
  input  logic [WORD_WIDTH-1:0] load_data,
  output logic                  load_ready,
  input  logic                  start,
  input  logic                  ready_for_inputs,
  output logic                  inputs_inbound,
  output logic                  pixel_value,
  output logic                  busy,
  output logic                  done
);
  localparam int WORDS = (NUM_PIXELS + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int WCW   = $clog2(WORDS + 1);
  localparam int PCW   = $clog2(NUM_PIXELS);
  localparam int FW    = WORDS * WORD_WIDTH;
  localparam int IW    = $clog2(FW);
  typedef enum logic [1:0] {LOAD, LOADED, WAIT_RDY, STREAM} state_t;
  state_t state;
  logic [WCW-1:0] word_cnt;
  logic [PCW-1:0] pix_cnt;
  logic [FW-1:0] frame;
  logic last_word, last_pix;
  logic [PCW-1:0] nxt_pix;
  assign last_word  = word_cnt == WCW'(WORDS - 1);
  assign last_pix   = pix_cnt == PCW'(NUM_PIXELS - 1);
  assign nxt_pix    = pix_cnt + 1'b1;
  assign load_ready = state == LOAD;
  assign busy       = state != LOAD;
  // Buffer is deliberately left out of reset; it is fully rewritten before every frame.
  always_ff @(posedge clk)
    if (load_ready && load_valid) frame[IW'(int'(word_cnt) * WORD_WIDTH) +: WORD_WIDTH] <= load_data;
  // pixel_value is registered one step ahead: pix_cnt always names the pixel currently on the output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= LOAD;
      word_cnt       <= '0;
      pix_cnt        <= '0;
      inputs_inbound <= 1'b0;
      pixel_value    <= 1'b0;
      done           <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        LOAD: if (load_valid) begin
          word_cnt <= last_word ? '0 : word_cnt + 1'b1;
          if (last_word) state <= LOADED;
        end
        LOADED: if (start) state <= WAIT_RDY;
        WAIT_RDY: if (ready_for_inputs) begin
          state          <= STREAM;
          pix_cnt        <= '0;
          inputs_inbound <= 1'b1;
          pixel_value    <= frame[0];
        end
        STREAM: if (last_pix) begin
          state          <= LOAD;
          pix_cnt        <= '0;
          inputs_inbound <= 1'b0;
          pixel_value    <= 1'b0;
          done           <= 1'b1;
        end else begin
          pix_cnt     <= nxt_pix;
          pixel_value <= frame[IW'(nxt_pix)];
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_pixel_stream_transmitter.sv
// tb_pixel_stream_transmitter: table-driven frames with a pixel scoreboard plus reset/corner sequences.
module tb_pixel_stream_transmitter;
  localparam int NP = 784, WW = 16, NW = 49;
  logic clk = 1'b0, reset, load_valid, start, ready_for_inputs;
  logic [WW-1:0] load_data;
  logic load_ready, inputs_inbound, pixel_value, busy, done;
  int checks = 0, errors = 0, cyc = 0, last_end = -1;
  logic exp_q[$];

  typedef struct {
    logic [WW-1:0] first, fill, last;
    int rdy_delay;
    bit throttle, start_in_load, drop_rdy;
    int exp_ones;
  } vec_t;
  vec_t vecs[5];

  pixel_stream_transmitter dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .start(start), .ready_for_inputs(ready_for_inputs),
    .inputs_inbound(inputs_inbound), .pixel_value(pixel_value), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic load_frame(input logic [WW-1:0] first, fill, last, input bit throttle, input bit sil);
    logic [WW-1:0] d;
    for (int w = 0; w < NW; w++) begin
      d = (w == 0) ? first : (w == NW - 1) ? last : fill;
      for (int i = 0; i < WW; i++) if (w * WW + i < NP) exp_q.push_back(d[i]);
      if (w == NW - 1) check("load_not_early", busy, 0);
      load_valid = 1'b1;
      load_data  = d;
      start      = sil && (w == 10);
      tick;
      start = 1'b0;
      if (throttle) begin
        load_valid = 1'b0;
        tick;
      end
    end
    load_valid = 1'b0;
    check("loaded_busy", busy, 1);
    check("loaded_ready", load_ready, 0);
  endtask

  // Stale starts must not launch a frame; words offered while not ready must be dropped.
  task automatic idle_loaded;
    load_valid = 1'b1;
    load_data  = '1;
    repeat (3) begin
      tick;
      check("no_auto_start", inputs_inbound, 0);
    end
    check("idle_busy", busy, 1);
    load_valid = 1'b0;
  endtask

  task automatic start_frame(input int rdy_delay);
    ready_for_inputs = (rdy_delay == 0);
    start = 1'b1;
    tick;
    start = 1'b0;
    check("start_no_inbound", inputs_inbound, 0);
    if (rdy_delay > 0) begin
      repeat (rdy_delay) tick;
      check("wait_rdy_hold", inputs_inbound, 0);
      check("wait_rdy_busy", busy, 1);
      ready_for_inputs = 1'b1;
    end
  endtask

  task automatic stream_frame(input int exp_ones, input bit drop_rdy);
    int lat = 0, len = 0, ones = 0, bad = 0;
    while (!inputs_inbound && lat < 100) begin
      tick;
      lat++;
    end
    check("start_latency", lat, 1);
    if (last_end >= 0) check("frame_gap_ge_51", (cyc - last_end) >= 51, 1);
    while (inputs_inbound && len < 2000) begin
      if (exp_q.size() == 0) bad++;
      else if (pixel_value !== exp_q.pop_front()) bad++;
      ones += int'(pixel_value);
      len++;
      start = (len == 50);
      if (drop_rdy && len == 100) ready_for_inputs = 1'b0;
      tick;
    end
    start = 1'b0;
    last_end = cyc;
    check("stream_len", len, NP);
    check("stream_ones", ones, exp_ones);
    check("pixel_mismatches", bad, 0);
    check("queue_drained", exp_q.size(), 0);
    check("done_pulse", done, 1);
    check("busy_fall", busy, 0);
    check("ready_after", load_ready, 1);
    check("pixel_zero_after", pixel_value, 0);
    ready_for_inputs = 1'b0;
    tick;
    check("done_one_cycle", done, 0);
  endtask

  task automatic run_vec(input vec_t v);
    load_frame(v.first, v.fill, v.last, v.throttle, v.start_in_load);
    idle_loaded();
    start_frame(v.rdy_delay);
    stream_frame(v.exp_ones, v.drop_rdy);
  endtask

  initial begin
    vecs[0] = '{16'hAAAA, 16'hAAAA, 16'hAAAA, 0, 1'b0, 1'b0, 1'b0, 392};
    vecs[1] = '{16'h0001, 16'h0000, 16'h8000, 0, 1'b0, 1'b0, 1'b0, 2};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 20, 1'b0, 1'b0, 1'b1, 784};
    vecs[3] = '{16'h0000, 16'h0000, 16'h0000, 0, 1'b0, 1'b0, 1'b0, 0};
    vecs[4] = '{16'h5555, 16'h5555, 16'h5555, 0, 1'b1, 1'b1, 1'b0, 392};
    reset = 1'b1;
    load_valid = 1'b0;
    load_data = '0;
    start = 1'b0;
    ready_for_inputs = 1'b0;
    tick;
    check("rst_load_ready", load_ready, 1);
    check("rst_inbound", inputs_inbound, 0);
    check("rst_pixel", pixel_value, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b0;
    tick;
    for (int k = 0; k < 5; k++) run_vec(vecs[k]);
    // Reset in the middle of a frame must drop inbound without waiting for a clock edge.
    load_frame(16'hAAAA, 16'hAAAA, 16'hAAAA, 1'b0, 1'b0);
    start_frame(0);
    tick;
    check("rst_mid_started", inputs_inbound, 1);
    repeat (300) tick;
    check("rst_mid_still_streaming", inputs_inbound, 1);
    #2 reset = 1'b1;
    #1;
    check("rst_async_inbound", inputs_inbound, 0);
    check("rst_async_ready", load_ready, 1);
    check("rst_async_busy", busy, 0);
    tick;
    reset = 1'b0;
    exp_q.delete();
    last_end = -1;
    ready_for_inputs = 1'b0;
    tick;
    run_vec('{16'h3C3C, 16'h3C3C, 16'h3C3C, 0, 1'b0, 1'b0, 1'b0, 392});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got 0 expected 1");
    $fatal(1, "timeout");
  end
endmodule
